// File: rtl/sl_receiver.sv
// SL two-wire line receiver: synchronizes sl0/sl1, classifies symbol excursions,
// and assembles 8/16/32-bit frames with parity, framing and timeout checks.
`timescale 1ns/1ps
module sl_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sl0,
   input  logic        sl1,
   input  logic [1:0]  mode,
   output logic [31:0] data,
   output logic        valid,
   output logic        parity_err,
   output logic        frame_err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, RX, WAIT_IDLE} state_t;

   localparam logic [15:0] GAP_LIMIT = 16'(TIMEOUT - 1);

   function automatic logic [5:0] word_len(input logic [1:0] m);
      case (m)
         2'd0:    return 6'd8;
         2'd1:    return 6'd16;
         default: return 6'd32;
      endcase
   endfunction

   logic [SYNC_STAGES-1:0] sync0_p0, sync1_p0;
   logic                   l0, l1, lines_idle;
   logic                   in_exc, low0, low1;
   logic                   sym_done, sym_zero, sym_one, sym_stop;
   state_t                 state;
   logic [1:0]             mode_q;
   logic [5:0]             bitcnt, n_len;
   logic [31:0]            shreg;
   logic                   zpar, perr;
   logic [15:0]            gap;

   // Stage p0: pin synchronizers, preset high so reset release never fakes a symbol
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync0_p0 <= '1;
         sync1_p0 <= '1;
      end else begin
         sync0_p0 <= {sync0_p0[SYNC_STAGES-2:0], sl0};
         sync1_p0 <= {sync1_p0[SYNC_STAGES-2:0], sl1};
      end
   end

   assign l0         = sync0_p0[SYNC_STAGES-1];
   assign l1         = sync1_p0[SYNC_STAGES-1];
   assign lines_idle = l0 & l1;

   // Stage p1: accumulate low flags over one excursion; it completes when lines return to 11
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_exc <= 1'b0;
         low0   <= 1'b0;
         low1   <= 1'b0;
      end else if (!lines_idle) begin
         in_exc <= 1'b1;
         low0   <= low0 | ~l0;
         low1   <= low1 | ~l1;
      end else begin
         in_exc <= 1'b0;
         low0   <= 1'b0;
         low1   <= 1'b0;
      end
   end

   assign sym_done = in_exc & lines_idle;
   assign sym_zero = low0 & ~low1;
   assign sym_one  = low1 & ~low0;
   assign sym_stop = low0 & low1;
   assign n_len    = word_len(mode_q);
   assign busy     = (state != IDLE) | in_exc | ~lines_idle;

   // Stage p2: frame FSM with registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         mode_q     <= 2'd0;
         bitcnt     <= 6'd0;
         shreg      <= 32'd0;
         zpar       <= 1'b0;
         perr       <= 1'b0;
         gap        <= 16'd0;
         data       <= 32'd0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (sym_done && !sym_stop) begin
                  mode_q <= mode;
                  shreg  <= {31'd0, sym_one};
                  zpar   <= sym_zero;
                  perr   <= 1'b0;
                  bitcnt <= 6'd1;
                  gap    <= 16'd0;
                  state  <= RX;
               end
            end
            RX: begin
               if (sym_done) begin
                  gap <= 16'd0;
                  if (sym_stop && bitcnt == n_len + 6'd1) begin
                     valid <= 1'b1;
                     state <= IDLE;
                     if (mode_q == 2'd3) begin
                        data       <= 32'd0;
                        parity_err <= 1'b0;
                        frame_err  <= 1'b1;
                     end else begin
                        data       <= shreg;
                        parity_err <= perr;
                        frame_err  <= 1'b0;
                     end
                  end else if (!sym_stop && bitcnt < n_len) begin
                     shreg[bitcnt[4:0]] <= sym_one;
                     zpar               <= zpar ^ sym_zero;
                     bitcnt             <= bitcnt + 6'd1;
                  end else if (!sym_stop && bitcnt == n_len) begin
                     // odd ZERO count demands a ZERO parity symbol
                     perr   <= (sym_zero != zpar);
                     bitcnt <= bitcnt + 6'd1;
                  end else begin
                     valid      <= 1'b1;
                     data       <= 32'd0;
                     parity_err <= 1'b0;
                     frame_err  <= 1'b1;
                     state      <= IDLE;
                  end
               end else if (gap == GAP_LIMIT) begin
                  valid      <= 1'b1;
                  data       <= 32'd0;
                  parity_err <= 1'b0;
                  frame_err  <= 1'b1;
                  state      <= lines_idle ? IDLE : WAIT_IDLE;
               end else begin
                  gap <= gap + 16'd1;
               end
            end
            WAIT_IDLE: begin
               if (lines_idle) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sl_receiver.md
# sl_receiver

Two-wire SL line receiver; the downstream counterpart of the SL transmitter. Decodes sl0/sl1 symbol streams into 8/16/32-bit words, checks the line parity symbol and framing, and presents each completed word with a one-cycle valid strobe and error flags. Sits between the board-level SL input pins and the bridge's register/APB side.

## Interface
- SYNC_STAGES, 2: synchronizer flops per line, legal 2..3.
- TIMEOUT, 255: max clock cycles between symbol completions inside a frame, 1..65535.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sl0  in  1  line 0, idle high; low pulse = data bit 0.
- sl1  in  1  line 1, idle high; low pulse = data bit 1.
- mode  in  2  word length: 0 = 8, 1 = 16, 2 = 32 bits, 3 = reserved.
- data  out  32  received word, LSB first on line, right-aligned, unused upper bits 0.
- valid  out  1  one-cycle strobe: data/parity_err/frame_err valid.
- parity_err  out  1  parity symbol mismatch, qualified by valid.
- frame_err  out  1  framing/timeout error, qualified by valid.
- busy  out  1  frame in progress.

## Operation
- Line encoding: symbol = excursion from 11 to non-11 and back to 11. During the excursion, per-line "low seen" flags accumulate on synchronized lines; classification when lines return to 11: only sl0 low = ZERO, only sl1 low = ONE, both low (any time) = STOP.
- Frame = N data symbols (N from mode), one parity symbol (ZERO or ONE), one STOP.
- Parity: count of ZERO data symbols odd -> parity symbol must be ZERO; even -> must be ONE. Mismatch -> parity_err=1, data still delivered.
- Bit k of the frame (k = 0 first) written to data bit k; bits >= N cleared at frame start.
- States: IDLE, RX, WAIT_IDLE.
  - IDLE: first completed ZERO/ONE -> latch mode, store bit 0, bitcnt=1, go RX. Completed STOP in IDLE discarded silently (no valid).
  - RX: ZERO/ONE with bitcnt<N -> store, bitcnt+1; bitcnt==N -> parity check; STOP with bitcnt==N+1 -> valid, go IDLE.
  - RX errors -> valid with frame_err=1, data=0, parity_err=0, go IDLE: STOP with bitcnt<=N (early stop, incl. missing parity); data symbol with bitcnt==N+1 (missing stop).
  - RX timeout: gap counter reset at each symbol completion; reaches TIMEOUT -> valid, frame_err=1, data=0; go WAIT_IDLE if lines not 11, else IDLE.
  - WAIT_IDLE: discard everything until synchronized lines == 11, then IDLE.
- mode sampled only at frame start; changes mid-frame ignored. mode 3: frame decoded with N=32 bit count but ends with frame_err=1, data=0.
- busy=1 in RX and WAIT_IDLE, and in IDLE while a symbol excursion is in progress.
- Symbol low phase and high gap of at least 1 clock each are accepted; no upper bound other than TIMEOUT.

## Timing
- Reset: data=0, valid=0, parity_err=0, frame_err=0, busy=0, state IDLE, counters 0, synchronizer flops preset to 1 (no false symbol on release).
- Input latency: SYNC_STAGES cycles from pin to decode logic.
- valid asserts in cycle SYNC_STAGES+1 after the first clk edge sampling both pins high at the end of the STOP symbol; held exactly 1 cycle.
- data, parity_err, frame_err updated with valid, then hold until next valid.
- Back-to-back frames: a new first data symbol may complete the cycle after valid; no gaps required.
- Reset mid-frame: immediate return to reset values; partial frame discarded, no valid.
- Timeout and symbol completion in the same cycle: completion wins, gap counter restarts.

## Test plan
- mode=0, transmitter-encoded 0xA5 (8 bits, ONE parity, STOP) -> valid once, data=0x000000A5, parity_err=0, frame_err=0, latency SYNC_STAGES+1 after STOP release.
- mode=2, 0xDEADBEEF followed immediately by 0x00000001 -> two valids, data 0xDEADBEEF then 0x00000001, no errors.
- mode=1, 0x1234 with parity symbol inverted -> valid, data=0x00001234, parity_err=1, frame_err=0.
- mode=0, STOP after 5 data bits -> valid, frame_err=1, data=0; following correct 0x3C frame -> data=0x3C, no errors.
- mode=0, sl0 held low after bit 3 for 300 cycles (TIMEOUT=255) -> valid with frame_err=1 at gap count 255; no further valid until lines 11 and next frame.
- reset asserted mid 32-bit frame, then released and 0x55 sent in mode 0 -> no valid for partial frame; data=0x55, no errors.
